// File: rtl/rect_bounce_renderer.sv
`default_nettype none
// ============================================================================
// Module   : rect_bounce_renderer
// Purpose  : Paints one frame per tick (solid background plus a filled
//            rectangle) into the st7789 frame buffer, pulses UPDATE, then
//            moves the rectangle one pixel diagonally and bounces it off the
//            screen edges.
// Revision : 1.0 - initial release
// ============================================================================
module rect_bounce_renderer #(
    parameter int          X_LIMIT  = 240,
    parameter int          Y_LIMIT  = 240,
    parameter int          RECT_W   = 40,
    parameter int          RECT_H   = 40,
    parameter logic [23:0] BG_COLOR = 24'h000000,
    parameter logic [23:0] FG_COLOR = 24'hFF8000
) (
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic                                         ENABLE,
    input  logic                                         FRAME_TICK,
    output logic [$clog2(X_LIMIT)+$clog2(Y_LIMIT)-1:0]   WRITE_RAM_ADDRESS,
    output logic [7:0]                                   WRITE_RAM_COLOR_R,
    output logic [7:0]                                   WRITE_RAM_COLOR_G,
    output logic [7:0]                                   WRITE_RAM_COLOR_B,
    output logic                                         WRITE_RAM,
    output logic                                         UPDATE,
    output logic                                         BUSY,
    output logic [$clog2(X_LIMIT)-1:0]                   RECT_X,
    output logic [$clog2(Y_LIMIT)-1:0]                   RECT_Y
);

    localparam int c_XW  = $clog2(X_LIMIT);
    localparam int c_YW  = $clog2(Y_LIMIT);
    // One extra bit so that position + size never wraps.
    localparam int c_XCW = c_XW + 1;
    localparam int c_YCW = c_YW + 1;

    localparam logic [c_XW-1:0]  c_X_MAX = c_XW'(X_LIMIT - 1);
    localparam logic [c_YW-1:0]  c_Y_MAX = c_YW'(Y_LIMIT - 1);
    localparam logic [c_XCW-1:0] c_X_LIM = c_XCW'(X_LIMIT);
    localparam logic [c_YCW-1:0] c_Y_LIM = c_YCW'(Y_LIMIT);
    localparam logic [c_XCW-1:0] c_RW    = c_XCW'(RECT_W);
    localparam logic [c_YCW-1:0] c_RH    = c_YCW'(RECT_H);
    localparam bit               c_X_FULL = (RECT_W == X_LIMIT);
    localparam bit               c_Y_FULL = (RECT_H == Y_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_UPD  = 2'd2
    } state_t;

    state_t            r_state_q,  w_state_d;
    logic [c_XW-1:0]   r_x_q,      w_x_d;
    logic [c_YW-1:0]   r_y_q,      w_y_d;
    logic [c_XW-1:0]   r_rect_x_q, w_rect_x_d;
    logic [c_YW-1:0]   r_rect_y_q, w_rect_y_d;
    logic              r_x_rev_q,  w_x_rev_d;
    logic              r_y_rev_q,  w_y_rev_d;
    logic              r_wr_q,     w_wr_d;
    logic              r_upd_q,    w_upd_d;
    logic              r_busy_q,   w_busy_d;
    logic [23:0]       r_color_q,  w_color_d;

    logic [c_XCW-1:0]  w_x_end;
    logic [c_YCW-1:0]  w_y_end;
    logic              w_fg;

    assign w_x_end = {1'b0, r_rect_x_q} + c_RW;
    assign w_y_end = {1'b0, r_rect_y_q} + c_RH;

    always_comb begin
        w_state_d  = r_state_q;
        w_x_d      = r_x_q;
        w_y_d      = r_y_q;
        w_rect_x_d = r_rect_x_q;
        w_rect_y_d = r_rect_y_q;
        w_x_rev_d  = r_x_rev_q;
        w_y_rev_d  = r_y_rev_q;

        case (r_state_q)
            S_IDLE: begin
                if (ENABLE && FRAME_TICK) begin
                    w_state_d = S_DRAW;
                    w_x_d     = '0;
                    w_y_d     = '0;
                end
            end
            S_DRAW: begin
                if (r_x_q == c_X_MAX) begin
                    w_x_d = '0;
                    if (r_y_q == c_Y_MAX) begin
                        w_state_d = S_UPD;
                    end else begin
                        w_y_d = r_y_q + 1'b1;
                    end
                end else begin
                    w_x_d = r_x_q + 1'b1;
                end
            end
            S_UPD: begin
                w_state_d = S_IDLE;
                // Horizontal step: reverse at an edge, then move one pixel.
                if (c_X_FULL) begin
                    w_rect_x_d = '0;
                end else if (!r_x_rev_q && (w_x_end == c_X_LIM)) begin
                    w_x_rev_d  = 1'b1;
                    w_rect_x_d = r_rect_x_q - 1'b1;
                end else if (r_x_rev_q && (r_rect_x_q == '0)) begin
                    w_x_rev_d  = 1'b0;
                    w_rect_x_d = r_rect_x_q + 1'b1;
                end else if (r_x_rev_q) begin
                    w_rect_x_d = r_rect_x_q - 1'b1;
                end else begin
                    w_rect_x_d = r_rect_x_q + 1'b1;
                end
                // Vertical step mirrors the horizontal one.
                if (c_Y_FULL) begin
                    w_rect_y_d = '0;
                end else if (!r_y_rev_q && (w_y_end == c_Y_LIM)) begin
                    w_y_rev_d  = 1'b1;
                    w_rect_y_d = r_rect_y_q - 1'b1;
                end else if (r_y_rev_q && (r_rect_y_q == '0)) begin
                    w_y_rev_d  = 1'b0;
                    w_rect_y_d = r_rect_y_q + 1'b1;
                end else if (r_y_rev_q) begin
                    w_rect_y_d = r_rect_y_q - 1'b1;
                end else begin
                    w_rect_y_d = r_rect_y_q + 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Colour is computed for the pixel that will be on the address bus next cycle.
    always_comb begin
        w_fg = (w_x_d >= r_rect_x_q) && ({1'b0, w_x_d} < w_x_end) &&
               (w_y_d >= r_rect_y_q) && ({1'b0, w_y_d} < w_y_end);
        w_color_d = w_fg ? FG_COLOR : BG_COLOR;
        w_wr_d    = (w_state_d == S_DRAW);
        w_upd_d   = (w_state_d == S_UPD);
        w_busy_d  = (w_state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q  <= S_IDLE;
            r_x_q      <= '0;
            r_y_q      <= '0;
            r_rect_x_q <= '0;
            r_rect_y_q <= '0;
            r_x_rev_q  <= 1'b0;
            r_y_rev_q  <= 1'b0;
            r_wr_q     <= 1'b0;
            r_upd_q    <= 1'b0;
            r_busy_q   <= 1'b0;
            r_color_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_x_q      <= w_x_d;
            r_y_q      <= w_y_d;
            r_rect_x_q <= w_rect_x_d;
            r_rect_y_q <= w_rect_y_d;
            r_x_rev_q  <= w_x_rev_d;
            r_y_rev_q  <= w_y_rev_d;
            r_wr_q     <= w_wr_d;
            r_upd_q    <= w_upd_d;
            r_busy_q   <= w_busy_d;
            r_color_q  <= w_color_d;
        end
    end

    assign WRITE_RAM_ADDRESS = {r_y_q, r_x_q};
    assign WRITE_RAM_COLOR_R = r_color_q[23:16];
    assign WRITE_RAM_COLOR_G = r_color_q[15:8];
    assign WRITE_RAM_COLOR_B = r_color_q[7:0];
    assign WRITE_RAM         = r_wr_q;
    assign UPDATE            = r_upd_q;
    assign BUSY              = r_busy_q;
    assign RECT_X            = r_rect_x_q;
    assign RECT_Y            = r_rect_y_q;

endmodule
`default_nettype wire
